// File: rtl/prf_wr_arbiter_pkg.sv
// rtl/prf_wr_arbiter_pkg.sv - shared types, sizes and PR field helpers for PRF writeback arbitration
package prf_wr_arbiter_pkg;

  localparam int XLEN                     = 32;
  localparam int PR_COUNT                 = 128;
  localparam int LOG_PR_COUNT             = $clog2(PR_COUNT);
  localparam int PRF_BANK_COUNT           = 4;
  localparam int LOG_PRF_BANK_COUNT       = $clog2(PRF_BANK_COUNT);
  localparam int PRF_WR_COUNT             = 8;
  localparam int LOG_PRF_WR_COUNT         = $clog2(PRF_WR_COUNT);
  localparam int PRF_WR_INPUT_BUFFER_SIZE = 2;

  typedef logic [XLEN-1:0]                              XLEN_t;
  typedef logic [LOG_PR_COUNT-1:0]                      PR_t;
  typedef logic [LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0]   upper_PR_t;
  typedef logic [LOG_PRF_BANK_COUNT-1:0]                PR_bank_t;
  typedef logic [LOG_PRF_WR_COUNT-1:0]                  wr_idx_t;

  // Requester slot assignment on the writeback side
  typedef enum logic [LOG_PRF_WR_COUNT-1:0] {
    WR_SRC_WR_BUF    = 3'd0,
    WR_SRC_LDU_BANK0 = 3'd1,
    WR_SRC_LDU_BANK1 = 3'd2,
    WR_SRC_ALU_REG   = 3'd3,
    WR_SRC_MDU       = 3'd4,
    WR_SRC_ALU_IMM   = 3'd5,
    WR_SRC_BRU       = 3'd6,
    WR_SRC_SYSU      = 3'd7
  } wr_src_e;

  // One buffered writeback: destination PR plus the value to write
  typedef struct packed {
    PR_t   pr;
    XLEN_t data;
  } prf_wr_entry_t;

  // Low PR bits select the bank
  function automatic PR_bank_t PR_bank_bits(input PR_t pr);
    return pr[LOG_PRF_BANK_COUNT-1:0];
  endfunction

  // Remaining PR bits select the row inside the bank
  function automatic upper_PR_t upper_PR_bits(input PR_t pr);
    return pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
  endfunction

  // Requester index base+off, wrapping past the last requester back to 0
  function automatic wr_idx_t wr_idx_wrap(input wr_idx_t base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= PRF_WR_COUNT) sum = sum - PRF_WR_COUNT;
    return wr_idx_t'(sum);
  endfunction

endpackage

// File: rtl/prf_wr_arbiter_if.sv
// rtl/prf_wr_arbiter_if.sv - requester-side and bank-side signal bundle for the PRF writeback arbiter
interface prf_wr_arbiter_if;
  import prf_wr_arbiter_pkg::*;

  logic      [PRF_WR_COUNT-1:0]   wr_req_valid_by_wr;
  PR_t       [PRF_WR_COUNT-1:0]   wr_req_PR_by_wr;
  XLEN_t     [PRF_WR_COUNT-1:0]   wr_req_data_by_wr;
  logic      [PRF_WR_COUNT-1:0]   wr_req_ready_by_wr;

  logic      [PRF_BANK_COUNT-1:0] bank_WEN_by_bank;
  upper_PR_t [PRF_BANK_COUNT-1:0] bank_upper_PR_by_bank;
  XLEN_t     [PRF_BANK_COUNT-1:0] bank_data_by_bank;
  logic      [PRF_BANK_COUNT-1:0] complete_valid_by_bank;
  PR_t       [PRF_BANK_COUNT-1:0] complete_PR_by_bank;

  modport master (
    output wr_req_valid_by_wr, wr_req_PR_by_wr, wr_req_data_by_wr,
    input  wr_req_ready_by_wr,
    input  bank_WEN_by_bank, bank_upper_PR_by_bank, bank_data_by_bank,
    input  complete_valid_by_bank, complete_PR_by_bank
  );

  modport slave (
    input  wr_req_valid_by_wr, wr_req_PR_by_wr, wr_req_data_by_wr,
    output wr_req_ready_by_wr,
    output bank_WEN_by_bank, bank_upper_PR_by_bank, bank_data_by_bank,
    output complete_valid_by_bank, complete_PR_by_bank
  );

endinterface

// File: rtl/prf_wr_input_buffer.sv
// rtl/prf_wr_input_buffer.sv - small per-requester FIFO of pending PRF writes
module prf_wr_input_buffer
  import prf_wr_arbiter_pkg::*;
#(
  parameter int DEPTH = PRF_WR_INPUT_BUFFER_SIZE
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          i_valid,
  input  prf_wr_entry_t i_entry,
  input  logic          i_pop,
  output logic          o_ready,
  output logic          o_empty,
  output prf_wr_entry_t o_head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  prf_wr_entry_t    r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // Ready comes only from the registered count, so a full FIFO stays closed even while its head drains
  assign o_ready = (r_count < CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_head];
  assign w_push  = i_valid & o_ready;
  assign w_pop   = i_pop & ~o_empty;

  // Head/tail/count bookkeeping; reset throws away anything still buffered
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= next_ptr(r_tail);
      if (w_pop)  r_head <= next_ptr(r_head);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful below the count, so no reset needed
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_tail] <= i_entry;
  end

endmodule

// File: rtl/prf_wr_arbiter.sv
// rtl/prf_wr_arbiter.sv - buffers writeback requesters and round-robins them onto PRF bank write ports
module prf_wr_arbiter
  import prf_wr_arbiter_pkg::*;
(
  input logic             CLK,
  input logic             nRST,
  prf_wr_arbiter_if.slave bus
);

  prf_wr_entry_t                  w_in_entry [PRF_WR_COUNT];
  prf_wr_entry_t                  w_head     [PRF_WR_COUNT];
  logic      [PRF_WR_COUNT-1:0]   w_empty;
  logic      [PRF_WR_COUNT-1:0]   w_ready;
  logic      [PRF_WR_COUNT-1:0]   w_pop;
  logic      [PRF_WR_COUNT-1:0]   w_cand     [PRF_BANK_COUNT];
  logic      [PRF_BANK_COUNT-1:0] w_grant_valid;
  wr_idx_t                        w_grant_idx [PRF_BANK_COUNT];

  wr_idx_t                        r_rr_ptr   [PRF_BANK_COUNT];
  logic      [PRF_BANK_COUNT-1:0] r_wen;
  upper_PR_t [PRF_BANK_COUNT-1:0] r_upper_pr;
  XLEN_t     [PRF_BANK_COUNT-1:0] r_data;
  PR_t       [PRF_BANK_COUNT-1:0] r_pr;

  for (genvar gi = 0; gi < PRF_WR_COUNT; gi++) begin : g_buf
    assign w_in_entry[gi] = '{pr: bus.wr_req_PR_by_wr[gi], data: bus.wr_req_data_by_wr[gi]};

    prf_wr_input_buffer #(
      .DEPTH (PRF_WR_INPUT_BUFFER_SIZE)
    ) u_buf (
      .CLK     (CLK),
      .nRST    (nRST),
      .i_valid (bus.wr_req_valid_by_wr[gi]),
      .i_entry (w_in_entry[gi]),
      .i_pop   (w_pop[gi]),
      .o_ready (w_ready[gi]),
      .o_empty (w_empty[gi]),
      .o_head  (w_head[gi])
    );
  end

  assign bus.wr_req_ready_by_wr     = w_ready;
  assign bus.bank_WEN_by_bank       = r_wen;
  assign bus.bank_upper_PR_by_bank  = r_upper_pr;
  assign bus.bank_data_by_bank      = r_data;
  assign bus.complete_valid_by_bank = r_wen;
  assign bus.complete_PR_by_bank    = r_pr;

  // Per-bank candidate set: requesters holding a head entry that targets this bank
  always_comb begin
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      w_cand[b] = '0;
      for (int w = 0; w < PRF_WR_COUNT; w++) begin
        w_cand[b][w] = ~w_empty[w] & (PR_bank_bits(w_head[w].pr) == PR_bank_t'(b));
      end
    end
  end

  // Round-robin pick per bank starting at its pointer; a winner's head is popped this cycle
  always_comb begin
    w_grant_valid = '0;
    w_pop         = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      w_grant_idx[b] = '0;
      for (int k = 0; k < PRF_WR_COUNT; k++) begin
        if (!w_grant_valid[b] && w_cand[b][wr_idx_wrap(r_rr_ptr[b], k)]) begin
          w_grant_valid[b] = 1'b1;
          w_grant_idx[b]   = wr_idx_wrap(r_rr_ptr[b], k);
        end
      end
      if (w_grant_valid[b]) w_pop[w_grant_idx[b]] = 1'b1;
    end
  end

  // Register the winning write onto the bank ports and advance the pointer past the winner
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wen      <= '0;
      r_upper_pr <= '0;
      r_data     <= '0;
      r_pr       <= '0;
      for (int b = 0; b < PRF_BANK_COUNT; b++) r_rr_ptr[b] <= '0;
    end else begin
      r_wen <= w_grant_valid;
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        if (w_grant_valid[b]) begin
          r_upper_pr[b] <= upper_PR_bits(w_head[w_grant_idx[b]].pr);
          r_data[b]     <= w_head[w_grant_idx[b]].data;
          r_pr[b]       <= w_head[w_grant_idx[b]].pr;
          r_rr_ptr[b]   <= wr_idx_wrap(w_grant_idx[b], 1);
        end
      end
    end
  end

endmodule

// File: tb/tb_prf_wr_arbiter.sv
// tb/tb_prf_wr_arbiter.sv - self-checking bench for prf_wr_arbiter
module tb_prf_wr_arbiter;
  import prf_wr_arbiter_pkg::*;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  prf_wr_arbiter_if bus_if ();

  prf_wr_arbiter dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per requester, one round-robin pointer per bank
  prf_wr_entry_t mq [PRF_WR_COUNT][$];
  int m_rr   [PRF_BANK_COUNT];
  int m_wen  [PRF_BANK_COUNT];
  int m_upr  [PRF_BANK_COUNT];
  int m_cpr  [PRF_BANK_COUNT];
  logic [31:0] m_data [PRF_BANK_COUNT];
  int m_sz   [PRF_WR_COUNT];
  bit m_pop  [PRF_WR_COUNT];
  int m_start;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int w = 0; w < PRF_WR_COUNT; w++) mq[w].delete();
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        m_rr[b] = 0; m_wen[b] = 0; m_upr[b] = 0; m_cpr[b] = 0; m_data[b] = 0;
      end
    end else begin
      for (int w = 0; w < PRF_WR_COUNT; w++) begin
        m_sz[w]  = mq[w].size();
        m_pop[w] = 1'b0;
      end
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        m_wen[b] = 0;
        m_start  = m_rr[b];
        for (int k = 0; k < PRF_WR_COUNT; k++) begin
          int w;
          w = (m_start + k) % PRF_WR_COUNT;
          if (m_wen[b] == 0 && m_sz[w] > 0 && (int'(mq[w][0].pr) % PRF_BANK_COUNT) == b) begin
            m_wen[b]  = 1;
            m_upr[b]  = int'(mq[w][0].pr) / PRF_BANK_COUNT;
            m_cpr[b]  = int'(mq[w][0].pr);
            m_data[b] = mq[w][0].data;
            m_pop[w]  = 1'b1;
            m_rr[b]   = (w + 1) % PRF_WR_COUNT;
          end
        end
      end
      for (int w = 0; w < PRF_WR_COUNT; w++) begin
        if (m_pop[w]) void'(mq[w].pop_front());
        if (bus_if.wr_req_valid_by_wr[w] && m_sz[w] < PRF_WR_INPUT_BUFFER_SIZE)
          mq[w].push_back('{pr: bus_if.wr_req_PR_by_wr[w], data: bus_if.wr_req_data_by_wr[w]});
      end
    end
  end

  function automatic logic [PRF_WR_COUNT-1:0] exp_ready();
    logic [PRF_WR_COUNT-1:0] r;
    for (int w = 0; w < PRF_WR_COUNT; w++) r[w] = (mq[w].size() < PRF_WR_INPUT_BUFFER_SIZE);
    return r;
  endfunction

  // Cycle-by-cycle comparison against the model, sampled on the falling edge
  always @(negedge CLK) begin
    if (cmp_en) begin
      check("ready", bus_if.wr_req_ready_by_wr, exp_ready());
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        check($sformatf("wen[%0d]", b), bus_if.bank_WEN_by_bank[b], m_wen[b]);
        check($sformatf("cvalid[%0d]", b), bus_if.complete_valid_by_bank[b], m_wen[b]);
        check($sformatf("upr[%0d]", b), bus_if.bank_upper_PR_by_bank[b], m_upr[b]);
        check($sformatf("data[%0d]", b), bus_if.bank_data_by_bank[b], m_data[b]);
        check($sformatf("cpr[%0d]", b), bus_if.complete_PR_by_bank[b], m_cpr[b]);
      end
    end
  end

  // Bank 0 write log for the ordering check
  logic [31:0] obs0[$];
  always @(negedge CLK) begin
    if (bus_if.bank_WEN_by_bank[0]) obs0.push_back(bus_if.bank_data_by_bank[0]);
  end

  task automatic set_req(input int w, input logic [6:0] pr, input logic [31:0] d);
    bus_if.wr_req_valid_by_wr[w] = 1'b1;
    bus_if.wr_req_PR_by_wr[w]    = pr;
    bus_if.wr_req_data_by_wr[w]  = d;
  endtask

  task automatic clear_all();
    bus_if.wr_req_valid_by_wr = '0;
  endtask

  logic [31:0] t4_exp [6];

  initial begin
    bus_if.wr_req_valid_by_wr = '0;
    bus_if.wr_req_PR_by_wr    = '0;
    bus_if.wr_req_data_by_wr  = '0;
    t4_exp = '{32'hA0, 32'hB0, 32'hA1, 32'hB1, 32'hA2, 32'hB2};

    // Reset state
    repeat (2) @(negedge CLK);
    cmp_en = 1'b1;
    check("rst_wen", bus_if.bank_WEN_by_bank, 4'h0);
    check("rst_ready", bus_if.wr_req_ready_by_wr, 8'hFF);
    check("rst_cpr", bus_if.complete_PR_by_bank, '0);
    check("rst_data", bus_if.bank_data_by_bank, '0);
    @(negedge CLK);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);

    // 1: single write, two-cycle latency
    set_req(3, 7'h05, 32'hDEAD);
    @(negedge CLK);
    clear_all();
    check("t1_no_early_wen", bus_if.bank_WEN_by_bank, 4'h0);
    @(negedge CLK);
    check("t1_wen", bus_if.bank_WEN_by_bank, 4'b0010);
    check("t1_cvalid", bus_if.complete_valid_by_bank, 4'b0010);
    check("t1_upr", bus_if.bank_upper_PR_by_bank[1], 5'h01);
    check("t1_data", bus_if.bank_data_by_bank[1], 32'hDEAD);
    check("t1_cpr", bus_if.complete_PR_by_bank[1], 7'h05);
    @(negedge CLK);
    check("t1_wen_drop", bus_if.bank_WEN_by_bank, 4'h0);
    check("t1_data_hold", bus_if.bank_data_by_bank[1], 32'hDEAD);

    // 2: three requesters conflict on bank 2
    set_req(0, 7'h02, 32'h2000);
    set_req(2, 7'h06, 32'h2002);
    set_req(5, 7'h0A, 32'h2005);
    @(negedge CLK);
    clear_all();
    @(negedge CLK);
    check("t2_first", bus_if.complete_PR_by_bank[2], 7'h02);
    @(negedge CLK);
    check("t2_second", bus_if.complete_PR_by_bank[2], 7'h06);
    @(negedge CLK);
    check("t2_third", bus_if.complete_PR_by_bank[2], 7'h0A);
    check("t2_third_wen", bus_if.bank_WEN_by_bank[2], 1'b1);
    @(negedge CLK);

    // 3: four banks in parallel
    set_req(0, 7'h10, 32'h3000);
    set_req(1, 7'h21, 32'h3001);
    set_req(2, 7'h32, 32'h3002);
    set_req(3, 7'h43, 32'h3003);
    @(negedge CLK);
    clear_all();
    @(negedge CLK);
    check("t3_wen_all", bus_if.bank_WEN_by_bank, 4'hF);
    check("t3_cpr3", bus_if.complete_PR_by_bank[3], 7'h43);
    check("t3_upr2", bus_if.bank_upper_PR_by_bank[2], 5'h0C);
    @(negedge CLK);

    // 4: backpressure on wr1 while wr0 competes on bank 0 (bank 0 pointer first parked at 3)
    set_req(2, 7'h04, 32'h4444);
    @(negedge CLK);
    clear_all();
    repeat (2) @(negedge CLK);
    obs0.delete();
    set_req(0, 7'h08, 32'hA0);
    set_req(1, 7'h18, 32'hB0);
    @(negedge CLK);
    set_req(0, 7'h0C, 32'hA1);
    set_req(1, 7'h1C, 32'hB1);
    @(negedge CLK);
    check("t4_ready1_low", bus_if.wr_req_ready_by_wr[1], 1'b0);
    set_req(0, 7'h14, 32'hA2);
    set_req(1, 7'h20, 32'hB2);
    @(negedge CLK);
    check("t4_ready1_back", bus_if.wr_req_ready_by_wr[1], 1'b1);
    bus_if.wr_req_valid_by_wr[0] = 1'b0;
    @(negedge CLK);
    clear_all();
    repeat (6) @(negedge CLK);
    check("t4_count", obs0.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < obs0.size()) check($sformatf("t4_order%0d", i), obs0[i], t4_exp[i]);
      else check($sformatf("t4_order%0d", i), 64'hFFFF_FFFF, t4_exp[i]);
    end

    // 5: pointer wrap on bank 3 (parked at 7 by a wr6 write)
    set_req(6, 7'h0F, 32'h6666);
    @(negedge CLK);
    clear_all();
    repeat (2) @(negedge CLK);
    set_req(1, 7'h07, 32'h5001);
    set_req(7, 7'h0B, 32'h5007);
    @(negedge CLK);
    clear_all();
    @(negedge CLK);
    check("t5_wr7_first", bus_if.complete_PR_by_bank[3], 7'h0B);
    check("t5_wr7_data", bus_if.bank_data_by_bank[3], 32'h5007);
    @(negedge CLK);
    check("t5_wr1_next", bus_if.complete_PR_by_bank[3], 7'h07);
    @(negedge CLK);

    // 6: reset with five writes still buffered
    set_req(0, 7'h24, 32'h6000);
    set_req(1, 7'h28, 32'h6001);
    set_req(2, 7'h2C, 32'h6002);
    set_req(3, 7'h30, 32'h6003);
    set_req(4, 7'h34, 32'h6004);
    @(negedge CLK);
    clear_all();
    set_req(5, 7'h38, 32'h6005);
    @(negedge CLK);
    clear_all();
    check("t6_pre_wen", bus_if.bank_WEN_by_bank[0], 1'b1);
    #2 nRST = 1'b0;
    #1;
    check("t6_rst_wen", bus_if.bank_WEN_by_bank, 4'h0);
    check("t6_rst_cvalid", bus_if.complete_valid_by_bank, 4'h0);
    check("t6_rst_ready", bus_if.wr_req_ready_by_wr, 8'hFF);
    check("t6_rst_cpr0", bus_if.complete_PR_by_bank[0], 7'h00);
    check("t6_rst_data0", bus_if.bank_data_by_bank[0], 32'h0);
    @(negedge CLK);
    #2 nRST = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      check($sformatf("t6_quiet%0d", i), bus_if.bank_WEN_by_bank, 4'h0);
    end

    cmp_en = 1'b0;
    @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
